execute_commit: RTL and testbench

//   Consumer end of the execute-stage result/flags interface. Takes ALUResultE and

---
 rtl/execute_commit.sv | 159 +++++++++++++++
 tb/tb_execute_commit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/execute_commit.sv
// Execute-to-memory commit stage: evaluates the E instruction's condition code
// against the architectural NZCV register, gates its side effects, updates the
// flags and registers the result into the M stage. Latency: 1 cycle (E -> M).
// Backpressure: StallM freezes the M register and the flags; FlushM (which wins
// over StallM) loads a bubble into M and leaves the flags untouched.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   StallM, FlushM              hazard-unit hold / squash controls
//   ValidE, CondE, FlagWriteE   E instruction qualifiers
//   ALUFlags                    {N,Z,C,V} produced by the ALU for E
//   RegWriteE..PCSrcE           E-stage control requests
//   ALUResultE, WriteDataE,WA3E E-stage data and destination
//   CondExE                     combinational condition-pass for E
//   FlagsQ                      architectural {N,Z,C,V}
//   *M                          registered M-stage copies
module execute_commit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             StallM,
  input  logic             FlushM,
  input  logic             ValidE,
  input  logic [3:0]       CondE,
  input  logic [1:0]       FlagWriteE,
  input  logic [3:0]       ALUFlags,
  input  logic             RegWriteE,
  input  logic             MemWriteE,
  input  logic             MemtoRegE,
  input  logic             PCSrcE,
  input  logic [WIDTH-1:0] ALUResultE,
  input  logic [WIDTH-1:0] WriteDataE,
  input  logic [3:0]       WA3E,
  output logic             CondExE,
  output logic [3:0]       FlagsQ,
  output logic             ValidM,
  output logic             RegWriteM,
  output logic             MemWriteM,
  output logic             MemtoRegM,
  output logic             PCSrcM,
  output logic [WIDTH-1:0] ALUResultM,
  output logic [WIDTH-1:0] WriteDataM,
  output logic [3:0]       WA3M
);

  logic [3:0]       flags_q, flags_d;
  logic             valid_q, valid_d;
  logic             regwrite_q, regwrite_d;
  logic             memwrite_q, memwrite_d;
  logic             memtoreg_q, memtoreg_d;
  logic             pcsrc_q, pcsrc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]       wa3_q, wa3_d;

  logic flag_n, flag_z, flag_c, flag_v;
  logic cond_ex;
  logic go;

  // Condition uses the flags as they stand before this edge; there is no
  // forwarding of ALUFlags, so back-to-back dependents see the registered copy.
  assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

  always_comb begin
    cond_ex = 1'b0;
    case (CondE)
      4'b0000: cond_ex = flag_z;
      4'b0001: cond_ex = ~flag_z;
      4'b0010: cond_ex = flag_c;
      4'b0011: cond_ex = ~flag_c;
      4'b0100: cond_ex = flag_n;
      4'b0101: cond_ex = ~flag_n;
      4'b0110: cond_ex = flag_v;
      4'b0111: cond_ex = ~flag_v;
      4'b1000: cond_ex = flag_c & ~flag_z;
      4'b1001: cond_ex = ~flag_c | flag_z;
      4'b1010: cond_ex = (flag_n == flag_v);
      4'b1011: cond_ex = (flag_n != flag_v);
      4'b1100: cond_ex = ~flag_z & (flag_n == flag_v);
      4'b1101: cond_ex = flag_z | (flag_n != flag_v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  assign go = ValidE & cond_ex;

  always_comb begin
    flags_d    = flags_q;
    valid_d    = valid_q;
    regwrite_d = regwrite_q;
    memwrite_d = memwrite_q;
    memtoreg_d = memtoreg_q;
    pcsrc_d    = pcsrc_q;
    result_d   = result_q;
    wdata_d    = wdata_q;
    wa3_d      = wa3_q;
    if (FlushM) begin
      // Bubble wins over stall; the squashed instruction must not touch flags.
      valid_d    = 1'b0;
      regwrite_d = 1'b0;
      memwrite_d = 1'b0;
      memtoreg_d = 1'b0;
      pcsrc_d    = 1'b0;
      result_d   = '0;
      wdata_d    = '0;
      wa3_d      = '0;
    end else if (!StallM) begin
      // A failed condition still advances as a valid instruction, writes off.
      valid_d    = ValidE;
      regwrite_d = RegWriteE & go;
      memwrite_d = MemWriteE & go;
      memtoreg_d = MemtoRegE;
      pcsrc_d    = PCSrcE & go;
      result_d   = ALUResultE;
      wdata_d    = WriteDataE;
      wa3_d      = WA3E;
      if (go && FlagWriteE[1]) flags_d[3:2] = ALUFlags[3:2];
      if (go && FlagWriteE[0]) flags_d[1:0] = ALUFlags[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q    <= '0;
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      memwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      pcsrc_q    <= 1'b0;
      result_q   <= '0;
      wdata_q    <= '0;
      wa3_q      <= '0;
    end else begin
      flags_q    <= flags_d;
      valid_q    <= valid_d;
      regwrite_q <= regwrite_d;
      memwrite_q <= memwrite_d;
      memtoreg_q <= memtoreg_d;
      pcsrc_q    <= pcsrc_d;
      result_q   <= result_d;
      wdata_q    <= wdata_d;
      wa3_q      <= wa3_d;
    end
  end

  assign CondExE    = cond_ex;
  assign FlagsQ     = flags_q;
  assign ValidM     = valid_q;
  assign RegWriteM  = regwrite_q;
  assign MemWriteM  = memwrite_q;
  assign MemtoRegM  = memtoreg_q;
  assign PCSrcM     = pcsrc_q;
  assign ALUResultM = result_q;
  assign WriteDataM = wdata_q;
  assign WA3M       = wa3_q;

endmodule

// File: tb/tb_execute_commit.sv
module tb_execute_commit;
  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, StallM, FlushM, ValidE;
  logic [3:0] CondE, ALUFlags, WA3E;
  logic [1:0] FlagWriteE;
  logic RegWriteE, MemWriteE, MemtoRegE, PCSrcE;
  logic [W-1:0] ALUResultE, WriteDataE;
  logic CondExE;
  logic [3:0] FlagsQ, WA3M;
  logic ValidM, RegWriteM, MemWriteM, MemtoRegM, PCSrcM;
  logic [W-1:0] ALUResultM, WriteDataM;

  execute_commit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .StallM(StallM), .FlushM(FlushM), .ValidE(ValidE),
    .CondE(CondE), .FlagWriteE(FlagWriteE), .ALUFlags(ALUFlags),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .MemtoRegE(MemtoRegE),
    .PCSrcE(PCSrcE), .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .WA3E(WA3E),
    .CondExE(CondExE), .FlagsQ(FlagsQ), .ValidM(ValidM), .RegWriteM(RegWriteM),
    .MemWriteM(MemWriteM), .MemtoRegM(MemtoRegM), .PCSrcM(PCSrcM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .WA3M(WA3M)
  );

  typedef struct {
    bit rst, stall, flush, valid;
    bit [3:0] cond, aflags, wa;
    bit [1:0] fw;
    bit rw, mw, m2r, pcs;
    bit [31:0] res, wd;
  } in_t;

  // Architectural state as seen after an edge.
  typedef struct {
    bit [3:0] flags;
    bit valid, rw, mw, m2r, pcs;
    bit [31:0] res, wd;
    bit [3:0] wa;
  } st_t;

  typedef struct {
    bit   chk_cond;
    bit   cond;
    st_t  nxt;
  } exp_t;

  exp_t sb[$];
  st_t  model;
  bit   model_known = 0;
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Condition rule written in terms of the named ARM predicates.
  function automatic bit passes(input bit [3:0] c, input bit [3:0] f);
    bit n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      0: return z;          1: return !z;
      2: return cf;         3: return !cf;
      4: return n;          5: return !n;
      6: return v;          7: return !v;
      8: return cf && !z;   9: return !cf || z;
      10: return n == v;    11: return n != v;
      12: return !z && (n == v);
      13: return z || (n != v);
      14: return 1;
      default: return 0;
    endcase
  endfunction

  task automatic step(input in_t x);
    exp_t e;
    st_t  n;
    bit   g;
    @(negedge clk);
    reset = x.rst; StallM = x.stall; FlushM = x.flush; ValidE = x.valid;
    CondE = x.cond; FlagWriteE = x.fw; ALUFlags = x.aflags;
    RegWriteE = x.rw; MemWriteE = x.mw; MemtoRegE = x.m2r; PCSrcE = x.pcs;
    ALUResultE = x.res; WriteDataE = x.wd; WA3E = x.wa;
    e.chk_cond = model_known;
    e.cond = passes(x.cond, model.flags);
    g = x.valid && e.cond;
    n = model;
    if (x.rst) begin
      n = '{default: 0};
    end else if (x.flush) begin
      n = '{default: 0};
      n.flags = model.flags;
    end else if (!x.stall) begin
      n.valid = x.valid;
      n.rw = x.rw && g; n.mw = x.mw && g; n.pcs = x.pcs && g;
      n.m2r = x.m2r; n.res = x.res; n.wd = x.wd; n.wa = x.wa;
      if (g && x.fw[1]) n.flags[3:2] = x.aflags[3:2];
      if (g && x.fw[0]) n.flags[1:0] = x.aflags[1:0];
    end
    if (model_known || x.rst) begin
      e.nxt = n;
      sb.push_back(e);
    end
    model = n;
    if (x.rst) model_known = 1;
  endtask

  // Monitor: checks CondExE mid-cycle, then the registered state after the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.chk_cond) chk("CondExE", 32'(CondExE), 32'(e.cond));
        @(posedge clk);
        #1;
        chk("FlagsQ", 32'(FlagsQ), 32'(e.nxt.flags));
        chk("ValidM", 32'(ValidM), 32'(e.nxt.valid));
        chk("RegWriteM", 32'(RegWriteM), 32'(e.nxt.rw));
        chk("MemWriteM", 32'(MemWriteM), 32'(e.nxt.mw));
        chk("MemtoRegM", 32'(MemtoRegM), 32'(e.nxt.m2r));
        chk("PCSrcM", 32'(PCSrcM), 32'(e.nxt.pcs));
        chk("ALUResultM", ALUResultM, e.nxt.res);
        chk("WriteDataM", WriteDataM, e.nxt.wd);
        chk("WA3M", 32'(WA3M), 32'(e.nxt.wa));
      end
    end
  end

  function automatic in_t nop();
    in_t x = '{default: 0};
    x.cond = 4'b1110;
    return x;
  endfunction

  initial begin
    in_t x;
    int  wait_cyc;
    reset = 1; StallM = 0; FlushM = 0; ValidE = 0; CondE = 0; FlagWriteE = 0;
    ALUFlags = 0; RegWriteE = 0; MemWriteE = 0; MemtoRegE = 0; PCSrcE = 0;
    ALUResultE = 0; WriteDataE = 0; WA3E = 0;

    // 1: reset with every input high, then AL condition while still in reset.
    x = '{rst:1, stall:1, flush:1, valid:1, cond:4'hF, aflags:4'hF, wa:4'hF, fw:2'b11,
          rw:1, mw:1, m2r:1, pcs:1, res:32'hFFFF_FFFF, wd:32'hFFFF_FFFF};
    step(x);
    x.cond = 4'b1110;
    step(x);

    // 2: CMP sets Z, then BEQ sees it in the following cycle.
    x = nop(); x.valid = 1; x.fw = 2'b11; x.aflags = 4'b0100;
    step(x);
    x = nop(); x.valid = 1; x.cond = 4'b0000; x.pcs = 1; x.res = 32'h40;
    step(x);

    // 3: NE fails with Z set; result advances, writes and flag update suppressed.
    x = nop(); x.valid = 1; x.cond = 4'b0001; x.rw = 1; x.fw = 2'b11;
    x.aflags = 4'b1011; x.res = 32'h0000_00AA; x.wa = 4'd3;
    step(x);

    // 4: partial flag updates, then GE/GT with N=V=1, Z=0.
    x = nop(); x.valid = 1; x.fw = 2'b11; x.aflags = 4'b1111; step(x);
    x.fw = 2'b10; x.aflags = 4'b0000; step(x);
    x.fw = 2'b11; x.aflags = 4'b1001; step(x);
    x = nop(); x.valid = 1; x.cond = 4'b1010; x.rw = 1; step(x);
    x.cond = 4'b1100; x.mw = 1; step(x);

    // 5: two stalled cycles with changing E inputs, then release.
    for (int i = 0; i < 2; i++) begin
      x = nop(); x.stall = 1; x.valid = 1; x.fw = 2'b11; x.aflags = 4'(i + 2);
      x.rw = 1; x.res = 32'hBEEF_0000 + i; x.wd = 32'h1234 + i; x.wa = 4'(i + 7);
      step(x);
    end
    x.stall = 0; step(x);

    // 6: flush together with stall, carrying a flag write.
    x = nop(); x.stall = 1; x.flush = 1; x.valid = 1; x.fw = 2'b11;
    x.aflags = 4'b1010; x.rw = 1; x.mw = 1; x.pcs = 1; x.m2r = 1;
    x.res = 32'h5555; x.wd = 32'h6666; x.wa = 4'd9;
    step(x);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      x.rst    = ($urandom_range(0, 49) == 0);
      x.stall  = ($urandom_range(0, 4) == 0);
      x.flush  = ($urandom_range(0, 6) == 0);
      x.valid  = ($urandom_range(0, 5) != 0);
      x.cond   = 4'($urandom);
      x.fw     = 2'($urandom);
      x.aflags = 4'($urandom);
      x.wa     = 4'($urandom);
      x.rw = 1'($urandom); x.mw = 1'($urandom);
      x.m2r = 1'($urandom); x.pcs = 1'($urandom);
      x.res = $urandom; x.wd = $urandom;
      step(x);
    end

    @(negedge clk);
    reset = 0; StallM = 1; FlushM = 0;
    wait_cyc = 0;
    while (sb.size() > 0 && wait_cyc < 20) begin
      @(negedge clk);
      wait_cyc++;
    end
    @(posedge clk); #2;
    if (sb.size() > 0) begin
      bad++;
      total++;
      $display("FAIL drain left=%0d required=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
